// File: rtl/hub_link_arbiter.sv
// hub_link_arbiter: round-robin arbiter that shares one serializer input
// among NUM_PORTS FWFT requesters. Each grant moves a burst of up to
// MAX_BURST words. Data, source index and pop strobes are combinational
// from the registered grant, so a granted word reaches the link with no
// added latency. Every grant is preceded by one IDLE bubble cycle.
module hub_link_arbiter #(
  parameter  int NUM_PORTS      = 4,
  parameter  int HUB_FIFO_WIDTH = 32,
  parameter  int MAX_BURST      = 4,
  localparam int ID_WIDTH       = $clog2(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS*HUB_FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [HUB_FIFO_WIDTH-1:0]           out_data,
  output logic [ID_WIDTH-1:0]                 out_src,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_next;
  logic [ID_WIDTH-1:0] grant_idx, grant_idx_next;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_next;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                at_last;

  // Port index "base + off", wrapping from NUM_PORTS-1 back to 0.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int                  off);
    return ID_WIDTH'((int'(base) + off) % NUM_PORTS);
  endfunction

  assign at_last = (beat_cnt == BEAT_W'(MAX_BURST - 1));

  // Rotating-priority scan starting at rr_ptr. Scanning from the farthest
  // offset down lets the nearest valid port overwrite earlier hits.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  // State register together with the pointer, grant and beat registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements are in.
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_ptr_next;
      grant_idx <= grant_idx_next;
      beat_cnt  <= beat_cnt_next;
    end
  end

  // Next-state logic: take a grant from IDLE, and end a burst on its last beat
  // or as soon as the granted port runs dry. A stall (out_ready low) holds.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    grant_idx_next = grant_idx;
    beat_cnt_next  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          grant_idx_next = pick_idx;
          beat_cnt_next  = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (!req_valid[grant_idx]) begin
          state_next  = IDLE;
          rr_ptr_next = wrap_add(grant_idx, 1);
        end else if (out_ready) begin
          if (at_last) begin
            state_next  = IDLE;
            rr_ptr_next = wrap_add(grant_idx, 1);
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: forward the granted port. Outputs are also held off while
  // reset is high, so a word presented during a mid-burst reset is not popped.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_src   = '0;
    out_data  = '0;
    req_ready = '0;
    if (state == GRANT && !reset) begin
      busy                 = 1'b1;
      out_src              = grant_idx;
      out_data             = req_data[grant_idx*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
      out_valid            = req_valid[grant_idx];
      req_ready[grant_idx] = out_ready && req_valid[grant_idx];
      out_last             = out_valid && at_last;
    end
  end

endmodule

// File: tb/tb_hub_link_arbiter.sv
// tb_hub_link_arbiter: directed bench for hub_link_arbiter. Instance "a" runs
// with MAX_BURST=4 and instance "b" with MAX_BURST=1. Both are fed by FWFT
// queue models. Each cycle the outputs are captured on the falling edge and
// compared with hand-derived expectations.
module tb_hub_link_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           out_ready = 1'b1;

  logic [N*W-1:0] a_req_data, b_req_data;
  logic [N-1:0]   a_req_valid, b_req_valid;
  logic [N-1:0]   a_req_ready, b_req_ready;
  logic [W-1:0]   a_out_data, b_out_data;
  logic [1:0]     a_out_src, b_out_src;
  logic           a_out_valid, b_out_valid;
  logic           a_out_last, b_out_last;
  logic           a_busy, b_busy;

  // Requester FIFOs: entries 0..3 feed instance a, entries 4..7 feed instance b.
  logic [W-1:0]   q [8][$];

  // Outputs captured on the falling edge; index 0 is instance a, index 1 is b.
  logic           o_valid [2];
  logic           o_busy  [2];
  logic           o_last  [2];
  logic [1:0]     o_src   [2];
  logic [W-1:0]   o_data  [2];
  logic [N-1:0]   o_ready [2];
  logic           o_oready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hub_link_arbiter #(.NUM_PORTS(N), .HUB_FIFO_WIDTH(W), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_data(a_req_data), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_last(a_out_last), .busy(a_busy)
  );

  hub_link_arbiter #(.NUM_PORTS(N), .HUB_FIFO_WIDTH(W), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_data(b_req_data), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_last(b_out_last), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the head of every requester queue (FWFT: valid means non-empty).
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      a_req_valid[i]       = (q[i].size() != 0);
      a_req_data[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
      b_req_valid[i]       = (q[i+4].size() != 0);
      b_req_data[i*W +: W] = (q[i+4].size() != 0) ? q[i+4][0] : '0;
    end
  endtask

  // One clock: capture outputs on the falling edge, then apply the pops
  // the DUT strobed just after the rising edge and re-present the heads.
  task automatic cycle();
    @(negedge clk);
    o_valid[0] = a_out_valid; o_busy[0] = a_busy; o_last[0] = a_out_last;
    o_src[0]   = a_out_src;   o_data[0] = a_out_data; o_ready[0] = a_req_ready;
    o_valid[1] = b_out_valid; o_busy[1] = b_busy; o_last[1] = b_out_last;
    o_src[1]   = b_out_src;   o_data[1] = b_out_data; o_ready[1] = b_req_ready;
    o_oready   = out_ready;
    check("onehot_a", ($countones(a_req_ready) <= 1), 1'b1);
    check("onehot_b", ($countones(b_req_ready) <= 1), 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (o_ready[0][i] && q[i].size() != 0)   void'(q[i].pop_front());
      if (o_ready[1][i] && q[i+4].size() != 0) void'(q[i+4].pop_front());
    end
    drive();
  endtask

  // Advance one cycle and compare instance d against an expected beat.
  task automatic exp_beat(input string tag, input int d, input bit v, input bit b,
                          input bit l, input int s, input logic [W-1:0] data);
    logic [N-1:0] rdy;
    cycle();
    rdy = (v && o_oready) ? (4'b0001 << s) : 4'b0000;
    check({tag, ".valid"}, o_valid[d], v);
    check({tag, ".busy"},  o_busy[d],  b);
    check({tag, ".last"},  o_last[d],  l);
    check({tag, ".ready"}, o_ready[d], rdy);
    if (v) begin
      check({tag, ".src"},  o_src[d],  s);
      check({tag, ".data"}, o_data[d], data);
    end
  endtask

  // Empty all requesters and hold reset for one cycle; outputs must be quiet.
  task automatic do_reset();
    for (int i = 0; i < 8; i++) q[i].delete();
    drive();
    reset = 1'b1;
    cycle();
    for (int d = 0; d < 2; d++) begin
      check("rst.valid", o_valid[d], 1'b0);
      check("rst.busy",  o_busy[d],  1'b0);
      check("rst.ready", o_ready[d], 4'b0000);
    end
    reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int beat;
    bit in_grant;

    drive();

    // Reset state.
    do_reset();
    exp_beat("t0_idle", 0, 0, 0, 0, 0, 0);
    check("t0_src",  o_src[0],  0);
    check("t0_data", o_data[0], 0);
    check("t0_last", o_last[0], 0);

    // Single requester: port 2 holds A0..A5.
    for (int j = 0; j < 6; j++) q[2].push_back(32'hA0 + j);
    drive();
    exp_beat("t1_idle0", 0, 0, 0, 0, 0, 0);
    exp_beat("t1_a0",    0, 1, 1, 0, 2, 32'hA0);
    exp_beat("t1_a1",    0, 1, 1, 0, 2, 32'hA1);
    exp_beat("t1_a2",    0, 1, 1, 0, 2, 32'hA2);
    exp_beat("t1_a3",    0, 1, 1, 1, 2, 32'hA3);
    exp_beat("t1_idle1", 0, 0, 0, 0, 0, 0);
    exp_beat("t1_a4",    0, 1, 1, 0, 2, 32'hA4);
    exp_beat("t1_a5",    0, 1, 1, 0, 2, 32'hA5);
    exp_beat("t1_dry",   0, 0, 1, 0, 2, 0);

    // rr_ptr is now 3: with ports 0 and 3 valid, 3 wins, then wrap to 0.
    q[0].push_back(32'hB0);
    q[3].push_back(32'hB3);
    drive();
    exp_beat("t1r_idle0", 0, 0, 0, 0, 0, 0);
    exp_beat("t1r_b3",    0, 1, 1, 0, 3, 32'hB3);
    exp_beat("t1r_dry3",  0, 0, 1, 0, 3, 0);
    exp_beat("t1r_idle1", 0, 0, 0, 0, 0, 0);
    exp_beat("t1r_b0",    0, 1, 1, 0, 0, 32'hB0);
    exp_beat("t1r_dry0",  0, 0, 1, 0, 0, 0);

    // Rotation skip: rr_ptr=1 with only ports 0 and 3 valid -> 3 then 0.
    q[0].push_back(32'hC0);
    q[3].push_back(32'hC3);
    drive();
    exp_beat("rot_idle0", 0, 0, 0, 0, 0, 0);
    exp_beat("rot_c3",    0, 1, 1, 0, 3, 32'hC3);
    exp_beat("rot_dry3",  0, 0, 1, 0, 3, 0);
    exp_beat("rot_idle1", 0, 0, 0, 0, 0, 0);
    exp_beat("rot_c0",    0, 1, 1, 0, 0, 32'hC0);
    exp_beat("rot_dry0",  0, 0, 1, 0, 0, 0);

    // All four ports continuously valid: grants 0,1,2,3,0 of four words.
    do_reset();
    for (int p = 0; p < N; p++)
      for (int j = 0; j < 8; j++) q[p].push_back(32'hD0000000 + p * 256 + j);
    drive();
    for (int k = 0; k < 5; k++) begin
      exp_beat($sformatf("rr_idle%0d", k), 0, 0, 0, 0, 0, 0);
      for (int b = 0; b < 4; b++)
        exp_beat($sformatf("rr_g%0d_b%0d", k, b), 0, 1, 1, (b == 3), k % 4,
                 32'hD0000000 + (k % 4) * 256 + (k / 4) * 4 + b);
    end

    // Backpressure: port 1 only, out_ready pattern 1,0,0 repeating.
    do_reset();
    for (int j = 0; j < 8; j++) q[1].push_back(32'hE0 + j);
    drive();
    n = 0;
    beat = 0;
    in_grant = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      cycle();
      if (!in_grant) begin
        check("bp_idle.valid", o_valid[0], 1'b0);
        check("bp_idle.ready", o_ready[0], 4'b0000);
        in_grant = 1'b1;
      end else begin
        check("bp.valid", o_valid[0], 1'b1);
        check("bp.src",   o_src[0],   1);
        check("bp.data",  o_data[0],  32'hE0 + n);
        check("bp.last",  o_last[0],  (beat == 3));
        check("bp.ready", o_ready[0], o_oready ? 4'b0010 : 4'b0000);
        if (o_oready) begin
          n++;
          if (beat == 3) begin
            beat = 0;
            in_grant = 1'b0;
          end else begin
            beat++;
          end
        end
      end
    end
    check("bp_words", n, 8);
    out_ready = 1'b1;

    // Reset after the 2nd beat of port 0's grant; F2 must survive.
    do_reset();
    for (int j = 0; j < 6; j++) q[0].push_back(32'hF0 + j);
    q[1].push_back(32'h60);
    drive();
    exp_beat("mr_idle0", 0, 0, 0, 0, 0, 0);
    exp_beat("mr_f0",    0, 1, 1, 0, 0, 32'hF0);
    exp_beat("mr_f1",    0, 1, 1, 0, 0, 32'hF1);
    reset = 1'b1;
    exp_beat("mr_inrst", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    exp_beat("mr_post",  0, 0, 0, 0, 0, 0);
    check("mr_post.src",  o_src[0],  0);
    check("mr_post.data", o_data[0], 0);
    exp_beat("mr_f2",    0, 1, 1, 0, 0, 32'hF2);
    exp_beat("mr_f3",    0, 1, 1, 0, 0, 32'hF3);
    exp_beat("mr_f4",    0, 1, 1, 0, 0, 32'hF4);
    exp_beat("mr_f5",    0, 1, 1, 1, 0, 32'hF5);
    exp_beat("mr_idle1", 0, 0, 0, 0, 0, 0);
    exp_beat("mr_g1",    0, 1, 1, 0, 1, 32'h60);
    exp_beat("mr_dry1",  0, 0, 1, 0, 1, 0);

    // MAX_BURST=1 instance: ports 0 and 1 alternate, last on every word.
    do_reset();
    for (int j = 0; j < 2; j++) begin
      q[4].push_back(32'h5000 + j);
      q[5].push_back(32'h5100 + j);
    end
    drive();
    for (int k = 0; k < 4; k++) begin
      exp_beat($sformatf("mb1_idle%0d", k), 1, 0, 0, 0, 0, 0);
      exp_beat($sformatf("mb1_w%0d", k), 1, 1, 1, 1, k % 2,
               32'h5000 + (k % 2) * 256 + k / 2);
    end
    exp_beat("mb1_end", 1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
